// File: rtl/four_path_distributor.sv
// Steers one input stream to one of four lanes, each buffered by a DEPTH-entry
// FIFO with an independent valid/ready handshake on the output side.
module four_path_distributor #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic [1:0]       select,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] data_out_0,
  output logic [WIDTH-1:0] data_out_1,
  output logic [WIDTH-1:0] data_out_2,
  output logic [WIDTH-1:0] data_out_3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [3:0]       lane_full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [3:0]       push;
  logic [3:0]       pop;
  logic [WIDTH-1:0] head [4];

  // Full lane refuses even when it pops this cycle: ready never depends on out_ready.
  assign in_ready = ~lane_full[select];

  for (genvar k = 0; k < 4; k++) begin : g_lane
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    assign push[k]      = in_valid & in_ready & (select == 2'(k));
    assign pop[k]       = out_valid[k] & out_ready[k];
    assign out_valid[k] = (count != '0);
    assign lane_full[k] = (count == FULL_CNT);
    assign head[k]      = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push[k]) begin
          mem[wr_ptr] <= data_in;
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (pop[k]) rd_ptr <= rd_ptr + 1'b1;
        case ({push[k], pop[k]})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  assign data_out_0 = head[0];
  assign data_out_1 = head[1];
  assign data_out_2 = head[2];
  assign data_out_3 = head[3];

endmodule

// File: tb/tb_four_path_distributor.sv
// Directed vector table plus hand-written streaming and async-reset sequences
// for four_path_distributor with WIDTH=32, DEPTH=2.
module tb_four_path_distributor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data_in;
  logic [1:0]  select;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_out_0, data_out_1, data_out_2, data_out_3;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [3:0]  lane_full;

  int unsigned checks = 0;
  int unsigned errors = 0;

  four_path_distributor #(.WIDTH(32), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .select(select),
    .in_valid(in_valid), .in_ready(in_ready),
    .data_out_0(data_out_0), .data_out_1(data_out_1),
    .data_out_2(data_out_2), .data_out_3(data_out_3),
    .out_valid(out_valid), .out_ready(out_ready), .lane_full(lane_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [1:0]  sel;
    logic [31:0] din;
    logic [3:0]  ordy;
    logic        rdy;   // in_ready before the edge
    logic [3:0]  ov;    // out_valid after the edge
    logic [3:0]  full;  // lane_full after the edge
    logic        chk;   // compare a lane head after the edge
    logic [1:0]  lane;
    logic [31:0] dout;
  } vec_t;

  vec_t vecs [12];

  function automatic vec_t mk(logic iv, logic [1:0] sel, logic [31:0] din, logic [3:0] ordy,
                              logic rdy, logic [3:0] ov, logic [3:0] full,
                              logic chk, logic [1:0] lane, logic [31:0] dout);
    vec_t v;
    v.iv = iv; v.sel = sel; v.din = din; v.ordy = ordy; v.rdy = rdy;
    v.ov = ov; v.full = full; v.chk = chk; v.lane = lane; v.dout = dout;
    return v;
  endfunction

  function automatic logic [31:0] head_of(logic [1:0] lane);
    case (lane)
      2'd0:    return data_out_0;
      2'd1:    return data_out_1;
      2'd2:    return data_out_2;
      default: return data_out_3;
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic iv, logic [1:0] sel, logic [31:0] din, logic [3:0] ordy);
    @(negedge clk);
    in_valid  = iv;
    select    = sel;
    data_in   = din;
    out_ready = ordy;
  endtask

  initial begin
    logic [3:0] prev_ov;

    rst_n = 1'b0; in_valid = 1'b0; select = 2'd0; data_in = '0; out_ready = '0;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset out_valid", 32'(out_valid), 32'h0);
    chk("reset lane_full", 32'(lane_full), 32'h0);
    chk("reset in_ready", 32'(in_ready), 32'h1);
    chk("reset data_out_0", data_out_0, 32'h0);
    chk("reset data_out_1", data_out_1, 32'h0);
    chk("reset data_out_2", data_out_2, 32'h0);
    chk("reset data_out_3", data_out_3, 32'h0);

    vecs[0]  = mk(1, 2, 32'h11, 4'b0000, 1, 4'b0100, 4'b0000, 1, 2, 32'h11);
    vecs[1]  = mk(1, 1, 32'h0A, 4'b0000, 1, 4'b0110, 4'b0000, 1, 1, 32'h0A);
    vecs[2]  = mk(1, 1, 32'h0B, 4'b0000, 1, 4'b0110, 4'b0010, 1, 1, 32'h0A);
    vecs[3]  = mk(1, 1, 32'h0E, 4'b0000, 0, 4'b0110, 4'b0010, 1, 1, 32'h0A);
    vecs[4]  = mk(1, 0, 32'h0C, 4'b0000, 1, 4'b0111, 4'b0010, 1, 0, 32'h0C);
    vecs[5]  = mk(1, 1, 32'h0D, 4'b0010, 0, 4'b0111, 4'b0000, 1, 1, 32'h0B);
    vecs[6]  = mk(1, 1, 32'h0D, 4'b0000, 1, 4'b0111, 4'b0010, 1, 1, 32'h0B);
    vecs[7]  = mk(0, 1, 32'h0F, 4'b0010, 0, 4'b0111, 4'b0000, 1, 1, 32'h0D);
    vecs[8]  = mk(0, 3, 32'h99, 4'b0010, 1, 4'b0101, 4'b0000, 1, 2, 32'h11);
    vecs[9]  = mk(0, 0, 32'h00, 4'b1111, 1, 4'b0000, 4'b0000, 0, 0, 32'h00);
    vecs[10] = mk(1, 0, 32'h55, 4'b1111, 1, 4'b0001, 4'b0000, 1, 0, 32'h55);
    vecs[11] = mk(1, 0, 32'h66, 4'b0001, 1, 4'b0001, 4'b0000, 1, 0, 32'h66);

    prev_ov = 4'b0000;
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].iv, vecs[i].sel, vecs[i].din, vecs[i].ordy);
      #1;
      chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
      chk($sformatf("v%0d out_valid pre-edge", i), 32'(out_valid), 32'(prev_ov));
      @(posedge clk); #1;
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
      chk($sformatf("v%0d lane_full", i), 32'(lane_full), 32'(vecs[i].full));
      if (vecs[i].chk)
        chk($sformatf("v%0d data_out_%0d", i, vecs[i].lane), head_of(vecs[i].lane), vecs[i].dout);
      prev_ov = vecs[i].ov;
    end

    // Back-to-back stream through lane 3 with its consumer always ready
    for (int w = 1; w <= 10; w++) begin
      drive(1'b1, 2'd3, 32'(w), 4'b1000);
      #1;
      chk($sformatf("stream w%0d in_ready", w), 32'(in_ready), 32'h1);
      @(posedge clk); #1;
      chk($sformatf("stream w%0d out_valid3", w), 32'(out_valid[3]), 32'h1);
      chk($sformatf("stream w%0d data_out_3", w), data_out_3, 32'(w));
    end
    drive(1'b0, 2'd3, 32'h0, 4'b1000);
    @(posedge clk); #1;
    chk("stream drained out_valid3", 32'(out_valid[3]), 32'h0);
    chk("stream lane0 untouched", data_out_0, 32'h66);

    // Fill lane 0 (66 already queued), then drop reset between clock edges
    drive(1'b1, 2'd0, 32'h77, 4'b0000);
    @(posedge clk); #1;
    chk("prefill lane_full", 32'(lane_full), 32'b0001);
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("async reset out_valid", 32'(out_valid), 32'h0);
    chk("async reset lane_full", 32'(lane_full), 32'h0);
    chk("async reset data_out_0", data_out_0, 32'h0);
    chk("async reset in_ready", 32'(in_ready), 32'h1);
    #13 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 2'd0, 32'h0, 4'b1111);
      @(posedge clk); #1;
      chk($sformatf("post-reset c%0d out_valid", c), 32'(out_valid), 32'h0);
      chk($sformatf("post-reset c%0d data_out_0", c), data_out_0, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
